// File: rtl/comparator_pkg.sv
// comparator_pkg: shared width default and search-controller state encoding
package comparator_pkg;
    localparam int DATA_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, PROBE, CHECK, DONE} state_t;
endpackage

// File: rtl/successive_approx_search_16_bit.sv
// successive_approx_search_16_bit: MSB-first binary search driving an external magnitude comparator
// Clock_In/Reset_In: clock, sync active-high reset; Start_In: request, sampled in IDLE only
// A_*_B_In: comparator flags for Probe_Out vs target, sampled on the same edge
// Probe_Out: candidate to comparator A side; Busy_Out: searching; Done_Out: 1-cycle result-valid pulse
// Found_Out/Flag_Error_Out/Result_Out: outcome, held until the next accepted Start_In
module successive_approx_search_16_bit
    import comparator_pkg::*;
#(
    parameter int DW = DATA_WIDTH
) (
    input  logic          Clock_In,
    input  logic          Reset_In,
    input  logic          Start_In,
    input  logic          A_Less_Than_B_In,
    input  logic          A_Equal_To_B_In,
    input  logic          A_Greater_Than_B_In,
    output logic [DW-1:0] Probe_Out,
    output logic          Busy_Out,
    output logic          Done_Out,
    output logic          Found_Out,
    output logic          Flag_Error_Out,
    output logic [DW-1:0] Result_Out
);
    localparam int IW = $clog2(DW);
    state_t        state;
    logic [DW-1:0] r;
    logic [IW-1:0] i;
    logic          one_hot;
    always_comb begin
        one_hot   = $onehot({A_Less_Than_B_In, A_Equal_To_B_In, A_Greater_Than_B_In});
        Probe_Out = state == PROBE ? r | (DW'(1) << i) : state == CHECK ? r : '0;
    end
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state          <= IDLE;
            r              <= '0;
            i              <= '0;
            Busy_Out       <= 1'b0;
            Done_Out       <= 1'b0;
            Found_Out      <= 1'b0;
            Flag_Error_Out <= 1'b0;
            Result_Out     <= '0;
        end else begin
            case (state)
                IDLE: if (Start_In) begin
                    r              <= '0;
                    i              <= IW'(DW - 1);
                    Found_Out      <= 1'b0;
                    Flag_Error_Out <= 1'b0;
                    Result_Out     <= '0;
                    Busy_Out       <= 1'b1;
                    state          <= PROBE;
                end
                PROBE: begin
                    if (!one_hot || A_Equal_To_B_In) begin
                        Flag_Error_Out <= !one_hot;
                        Found_Out      <= one_hot;
                        Result_Out     <= one_hot ? Probe_Out : r;
                        Busy_Out       <= 1'b0;
                        Done_Out       <= 1'b1;
                        state          <= DONE;
                    end else begin
                        if (A_Less_Than_B_In) r <= Probe_Out;
                        if (i == '0) state <= CHECK;
                        else i <= i - 1'b1;
                    end
                end
                CHECK: begin
                    Flag_Error_Out <= !one_hot;
                    Found_Out      <= one_hot && A_Equal_To_B_In;
                    Result_Out     <= r;
                    Busy_Out       <= 1'b0;
                    Done_Out       <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    Done_Out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_successive_approx_search_16_bit.sv
// tb_successive_approx_search_16_bit: scoreboard bench with a behavioural comparator on the probe
module tb_successive_approx_search_16_bit;
    typedef struct {
        logic [15:0] result;
        logic        found;
        logic        ferr;
        int          done_cyc;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] target = '0;
    logic [1:0]  mode = 2'd0;
    logic        lt, eq, gt;
    logic [15:0] probe, result;
    logic        busy, done, found, ferr;
    exp_t        exp_q[$];
    int          vectors = 0;
    int          misses = 0;
    always #5 clk = ~clk;
    // mode 0: honest comparator; 1: equal stuck low, reported as less; 2: all flags low
    assign lt = mode == 2'd2 ? 1'b0 : mode == 2'd1 ? probe <= target : probe < target;
    assign eq = mode == 2'd0 && probe == target;
    assign gt = mode != 2'd2 && probe > target;
    successive_approx_search_16_bit dut (
        .Clock_In(clk), .Reset_In(rst), .Start_In(start),
        .A_Less_Than_B_In(lt), .A_Equal_To_B_In(eq), .A_Greater_Than_B_In(gt),
        .Probe_Out(probe), .Busy_Out(busy), .Done_Out(done), .Found_Out(found),
        .Flag_Error_Out(ferr), .Result_Out(result)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            misses++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask
    function automatic int tz(input logic [15:0] v);
        for (int k = 0; k < 16; k++) if (v[k]) return k;
        return 16;
    endfunction
    task automatic push_exp(input logic [15:0] t, input logic [1:0] m);
        exp_t e;
        e.result   = m == 2'd2 ? 16'h0 : t;
        e.found    = m == 2'd0;
        e.ferr     = m == 2'd2;
        e.done_cyc = m == 2'd2 ? 2 : m == 2'd1 || t == 16'h0 ? 18 : 17 - tz(t);
        exp_q.push_back(e);
    endtask
    task automatic run(input logic [15:0] t, input logic [1:0] m, input bit poke);
        exp_t e;
        int   c, busy_n;
        bit   seen;
        target = t;
        mode   = m;
        push_exp(t, m);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        busy_n = 0;
        seen   = 0;
        for (c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = poke && c == 3;
            if (c == 1 && m != 2'd1) chk("first_probe", probe, 16'h8000);
            if (done) begin
                seen = 1;
                break;
            end
            busy_n += busy;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (!seen) chk("done_timeout", 0, 1);
        else begin
            chk("done_cycle", c, e.done_cyc);
            chk("busy_cycles", busy_n, e.done_cyc - 1);
            chk("busy_at_done", busy, 0);
            chk("result", result, e.result);
            chk("found", found, e.found);
            chk("flag_error", ferr, e.ferr);
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("result_held", result, e.result);
        end
    endtask
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_probe", probe, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {busy, done, found, ferr}, 0);
        @(posedge clk); #1 rst = 1'b0;
        run(16'h0000, 2'd0, 0);
        run(16'h8000, 2'd0, 0);
        run(16'hFFFF, 2'd0, 0);
        run(16'h1235, 2'd1, 0);
        run(16'h4321, 2'd2, 0);
        target = 16'h1234;
        mode   = 2'd0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_probe", probe, 0);
        for (int n = 0; n < 10; n++) run(16'($urandom_range(0, 65535)), 2'd0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
